// File: rtl/serial_to_parallel_4bits_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_to_parallel_4bits_pkg                                 |
// | Description : Shared word/counter widths and FSM state encoding.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package serial_to_parallel_4bits_pkg;

    localparam int WIDTH     = 4;
    localparam int CNT_WIDTH = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage : serial_to_parallel_4bits_pkg
`default_nettype wire

// File: rtl/serial_to_parallel_4bits_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_to_parallel_4bits_if                                  |
// | Description : Serial input / parallel output bundle for the deserializer. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface serial_to_parallel_4bits_if;
    import serial_to_parallel_4bits_pkg::*;

    logic                 sin;
    logic                 sin_valid;
    logic                 abort;
    logic [WIDTH-1:0]     Out;
    logic                 out_valid;
    logic [CNT_WIDTH-1:0] bit_cnt;
    logic                 busy;

    modport master (
        output sin, sin_valid, abort,
        input  Out, out_valid, bit_cnt, busy
    );

    modport slave (
        input  sin, sin_valid, abort,
        output Out, out_valid, bit_cnt, busy
    );

endinterface : serial_to_parallel_4bits_if
`default_nettype wire

// File: rtl/serial_to_parallel_4bits_bit_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bit_counter_2bits                                            |
// | Description : 2-bit up counter with async reset, sync clear and enable.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bit_counter_2bits
    import serial_to_parallel_4bits_pkg::*;
(
    input  wire                  clk,
    input  wire                  rst_n,
    input  wire                  sync_clr,
    input  wire                  en,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] r_count;

    // Synchronous clear wins over enable so completion/abort always land on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (sync_clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : bit_counter_2bits
`default_nettype wire

// File: rtl/serial_to_parallel_4bits.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_to_parallel_4bits                                     |
// | Description : MSB-first serial-to-parallel word assembler with abort.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module serial_to_parallel_4bits #(
    parameter int WIDTH = serial_to_parallel_4bits_pkg::WIDTH
) (
    input  wire                              clk,
    input  wire                              clear,
    serial_to_parallel_4bits_if.slave        bus
);
    import serial_to_parallel_4bits_pkg::*;

    state_t               r_state;
    logic [WIDTH-1:0]     r_shreg;
    logic [WIDTH-1:0]     r_out;
    logic                 r_out_valid;
    logic [CNT_WIDTH-1:0] w_cnt;
    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_next_word;

    assign w_accept    = bus.sin_valid & ~bus.abort;
    assign w_last      = (w_cnt == CNT_WIDTH'(WIDTH - 1));
    assign w_next_word = {r_shreg[WIDTH-2:0], bus.sin};

    bit_counter_2bits u_bit_counter (
        .clk      (clk),
        .rst_n    (clear),
        .sync_clr (bus.abort | (w_accept & w_last)),
        .en       (w_accept),
        .count    (w_cnt)
    );

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (bus.abort) begin
                r_state <= IDLE;
                r_shreg <= '0;
            end else if (bus.sin_valid) begin
                r_shreg <= w_next_word;
                if (w_last) begin
                    r_out       <= w_next_word;
                    r_out_valid <= 1'b1;
                    r_state     <= IDLE;
                end else begin
                    r_state     <= RECV;
                end
            end
        end
    end

    assign bus.Out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.bit_cnt   = w_cnt;
    assign bus.busy      = (r_state == RECV);

endmodule : serial_to_parallel_4bits
`default_nettype wire
